// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the synthetic key path.
//   - key_emitter_state_t : FSM state encoding of key_emitter
//   - LFSR_W / LFSR_TAPS / LFSR_DEFAULT_SEED : bounce generator LFSR
//   - DEF_* : default phase counts for a 50 MHz clk, shared with the
//             key debounce block (20 ms = 1_000_000 cycles)
//   - lfsr_next() : one Fibonacci step of the 16-bit LFSR
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BOUNCE_DN = 3'd1,
        ST_HOLD      = 3'd2,
        ST_BOUNCE_UP = 3'd3,
        ST_GAP       = 3'd4
    } key_emitter_state_t;

    localparam int          LFSR_W            = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam logic [19:0] DEF_BOUNCE_CNT = 20'd249_999;  // 5 ms
    localparam logic [15:0] DEF_TOGGLE_DIV = 16'd999;      // 20 us
    localparam logic [19:0] DEF_GAP_CNT    = 20'd999_999;  // 20 ms

    // Left shift; the XOR of the tapped bits enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/key_emitter_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used as the bounce noise source.
//   clk  in   system clock
//   rst  in   synchronous active-high reset, loads seed
//   load in   reload seed (takes priority over step)
//   seed in   value loaded on rst / load; must be non-zero
//   step in   advance one position
//   q    out  current LFSR contents
module lfsr16
    import key_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/key_emitter.sv
// key_emitter: synthetic push-button. On request it drives an active-low
// key line through press bounce, programmable hold, release bounce and a
// quiet gap, looking electrically like a raw mechanical key.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   press_req   in   request one press, sampled every cycle
//   hold_cycles in   low-hold length (0 behaves as 1), latched on accept
//   busy        out  high from accept until done
//   done        out  one-cycle pulse at sequence end (busy already low)
//   key_out     out  emulated key, active low, idle 1
//   state_dbg   out  current FSM state for observation
//
// Request handshake: press_req acts as "valid" and ~busy as "ready".
// A request is accepted on any clock edge where press_req=1 and busy=0
// (including the done cycle, so a held request runs back-to-back).
// Requests while busy=1 are dropped, never queued.
module key_emitter
    import key_pkg::*;
#(
    parameter logic [19:0] BOUNCE_CNT = DEF_BOUNCE_CNT,
    parameter logic [15:0] TOGGLE_DIV = DEF_TOGGLE_DIV,
    parameter logic [19:0] GAP_CNT    = DEF_GAP_CNT,
    parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               press_req,
    input  logic [23:0]        hold_cycles,
    output logic               busy,
    output logic               done,
    output logic               key_out,
    output key_emitter_state_t state_dbg
);

    key_emitter_state_t state, state_n;
    logic [19:0] phase, phase_n;      // bounce phase / gap counter
    logic [15:0] tog, tog_n;          // toggle divider inside bounce
    logic [23:0] hold_cnt, hold_cnt_n;
    logic [23:0] hold_len, hold_len_n;
    logic        key_n, busy_n, done_n;
    logic        lfsr_load, lfsr_step, tog_wrap;
    logic [15:0] lfsr_q, lfsr_nx;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (LFSR_SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // Value the LFSR takes on a step; its bit 0 is what key_out shows.
    assign lfsr_nx   = lfsr_next(lfsr_q);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= '0;
            tog      <= '0;
            hold_cnt <= '0;
            hold_len <= '0;
            key_out  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            tog      <= tog_n;
            hold_cnt <= hold_cnt_n;
            hold_len <= hold_len_n;
            key_out  <= key_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Outputs are registered: every *_n value is what the output shows in
    // the same cycle as state_n becomes the state.
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        tog_n      = tog;
        hold_cnt_n = hold_cnt;
        hold_len_n = hold_len;
        key_n      = key_out;
        busy_n     = busy;
        done_n     = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        tog_wrap   = 1'b0;

        case (state)
            ST_IDLE: begin
                key_n  = 1'b1;
                busy_n = 1'b0;
                if (press_req) begin
                    state_n    = ST_BOUNCE_DN;
                    busy_n     = 1'b1;
                    lfsr_load  = 1'b1;
                    phase_n    = '0;
                    tog_n      = '0;
                    hold_cnt_n = '0;
                    hold_len_n = (hold_cycles == '0) ? 24'd1 : hold_cycles;
                    // A one-cycle bounce phase is also its forced last cycle.
                    key_n      = (BOUNCE_CNT != '0);
                end
            end

            ST_BOUNCE_DN, ST_BOUNCE_UP: begin
                tog_wrap  = (tog == TOGGLE_DIV);
                lfsr_step = tog_wrap;
                tog_n     = tog_wrap ? 16'd0 : tog + 16'd1;
                if (phase == BOUNCE_CNT) begin
                    phase_n = '0;
                    tog_n   = '0;
                    if (state == ST_BOUNCE_DN) begin
                        state_n    = ST_HOLD;
                        hold_cnt_n = '0;
                        key_n      = 1'b0;
                    end else begin
                        state_n = ST_GAP;
                        key_n   = 1'b1;
                    end
                end else begin
                    phase_n = phase + 20'd1;
                    // The last phase cycle is forced to the settled level.
                    if (phase_n == BOUNCE_CNT) begin
                        key_n = (state == ST_BOUNCE_UP);
                    end else if (tog_wrap) begin
                        key_n = lfsr_nx[0];
                    end
                end
            end

            ST_HOLD: begin
                key_n = 1'b0;
                if (hold_cnt == hold_len - 24'd1) begin
                    state_n = ST_BOUNCE_UP;
                    phase_n = '0;
                    tog_n   = '0;
                    key_n   = (BOUNCE_CNT == '0);
                end else begin
                    hold_cnt_n = hold_cnt + 24'd1;
                end
            end

            ST_GAP: begin
                key_n = 1'b1;
                if (phase == GAP_CNT) begin
                    state_n = ST_IDLE;
                    phase_n = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    phase_n = phase + 20'd1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                key_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/key_emitter.md
# key_emitter

Synthetic push-button source for the key path: on a request it drives an active-low key line through a press bounce, a programmable hold, a release bounce and a quiet gap. Its output has the same electrical form as a raw mechanical key. It feeds the key debounce block in loopback self-test and in board bring-up, without a human pressing a button. Bounce is pseudo-random (LFSR), so debounce filtering is exercised realistically. Default counts assume a 50 MHz clk (20 ms = 1_000_000 cycles).

## Interface
- BOUNCE_CNT, 20'd249_999: each bounce phase lasts BOUNCE_CNT+1 cycles (5 ms).
- TOGGLE_DIV, 16'd999: key_out may change every TOGGLE_DIV+1 cycles during bounce.
- GAP_CNT, 20'd999_999: post-release quiet time is GAP_CNT+1 cycles.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset and at each accepted request; must be non-zero.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- press_req  in  1  request one press; sampled every cycle.
- hold_cycles  in  24  low-hold length in cycles; latched on accept.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at sequence end.
- key_out  out  1  emulated key, active low, idle 1.

## Operation
- States: IDLE, BOUNCE_DN, HOLD, BOUNCE_UP, GAP.
- IDLE: key_out=1 and busy=0. If press_req=1, latch hold_cycles (0 is treated as 1), reseed the LFSR, clear counters and go to BOUNCE_DN.
- press_req is ignored while busy=1. There is no queueing.
- BOUNCE_DN: a phase counter runs 0..BOUNCE_CNT.
  - Each time the toggle counter wraps at TOGGLE_DIV, the LFSR steps once and key_out takes lfsr[0].
  - key_out is forced to 0 on the last phase cycle, then the block goes to HOLD.
- HOLD: key_out=0 for exactly hold_cycles cycles, then BOUNCE_UP.
- BOUNCE_UP: same as BOUNCE_DN, except key_out is forced to 1 on the last cycle, then GAP.
- GAP: key_out=1 for GAP_CNT+1 cycles, then IDLE with done=1 for one cycle.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left. It steps only on toggle wraps inside bounce states.
- Counters are unsigned. Width overflow cannot occur because all compares use ==.
- rst (any state): state=IDLE, key_out=1, busy=0, done=0, all counters 0, LFSR=LFSR_SEED. rst takes priority over press_req in the same cycle.

## Timing
- Reset values: key_out=1, busy=0, done=0.
- All outputs are registered. press_req high in cycle N → busy=1 and state BOUNCE_DN from cycle N+1.
- Toggle counter is cleared on entry to each bounce state. The first LFSR step occurs TOGGLE_DIV+1 cycles after entry.
- Phase lengths: BOUNCE_DN B+1, HOLD H, BOUNCE_UP B+1, GAP G+1 cycles.
- done=1 and busy=0 in the same cycle, N+1+2(B+1)+H+G+1.
- A new press_req in that done cycle is accepted, giving back-to-back operation.
- press_req held high continuously → repeated presses, one per sequence.
- hold_cycles changes while busy have no effect.

## Structure
- Package key_pkg holds:
  - the state enum for key_emitter_state_t;
  - LFSR width, taps constant and default seed;
  - the 50 MHz-derived default count constants shared with the debounce block.
- One sub-module, lfsr16 (ports: clk, rst, load, seed, step, q).
- Top level key_emitter holds the FSM plus the phase, toggle and hold counters.

## Test plan
Simulation parameters unless noted: BOUNCE_CNT=15, TOGGLE_DIV=3, GAP_CNT=7.
- Reset: rst high for 3 cycles while press_req=1 → key_out=1, busy=0, done=0 throughout; no sequence starts after rst falls unless press_req is still high.
- Single press, hold_cycles=10, press_req pulsed at cycle 0:
  - busy rises at cycle 1;
  - key_out=0 on cycles 16–26;
  - key_out=1 on cycles 43–50;
  - done pulses at cycle 51, and busy falls at cycle 51.
- Bounce pattern: during BOUNCE_DN, key_out changes only at phase offsets 4, 8, 12 (within cycles 1–16), and the values match a reference LFSR model from seed 16'hACE1.
- Ignored request: a second press_req at cycle 20 → no effect; done occurs only at cycle 51.
- Edge cases:
  - hold_cycles=0 → HOLD lasts exactly 1 cycle;
  - press_req held high → a second busy period starts at cycle 52, with key_out falling again only after the bounce phase.
- Mid-operation reset, rst at cycle 20 (in HOLD) → cycle 21: key_out=1, busy=0, no done pulse; a later request replays the identical bounce sequence (same seed).
